// File: rtl/fir_serial_mc.sv
// Time-multiplexed multi-channel FIR: one shared multiplier walks the taps of the
// selected channel's delay line, optionally folding symmetric taps with a pre-add.
module fir_serial_mc #(
    parameter int DW   = 12,
    parameter int CW   = 12,
    parameter int TAPS = 8,
    parameter int CH   = 2,
    parameter int SYMM = 0,
    parameter int OW   = DW + CW + $clog2(TAPS),
    localparam int CHW = (CH > 1) ? $clog2(CH) : 1,
    localparam int AW  = $clog2(TAPS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic signed [DW-1:0] xin,
    input  logic [CHW-1:0]       xin_ch,
    input  logic                 coef_we,
    input  logic [AW-1:0]        coef_addr,
    input  logic signed [CW-1:0] coef_data,
    output logic                 busy,
    output logic signed [OW-1:0] yout,
    output logic [CHW-1:0]       yout_ch,
    output logic                 rdy,
    output logic                 err
);
    localparam int NC = (SYMM != 0) ? TAPS / 2 : TAPS;

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_DONE} state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [AW-1:0]         r_k;
    logic [CHW-1:0]        r_ch;
    logic signed [OW-1:0]  r_acc;
    logic signed [CW-1:0]  r_coef [NC];

    logic                  w_ch_ok;
    logic                  w_accept;
    logic                  w_coef_wr;
    logic                  w_last;
    logic [AW-1:0]         w_kb;
    logic signed [DW-1:0]  w_xa [CH];
    logic signed [DW-1:0]  w_xb [CH];
    logic signed [DW:0]    w_pre;
    logic signed [CW+DW:0] w_prod;

    assign w_ch_ok   = ({1'b0, xin_ch} < (CHW+1)'(CH));
    assign w_accept  = (r_state == S_IDLE) && en && w_ch_ok;
    assign w_coef_wr = (r_state == S_IDLE) && !en && coef_we &&
                       ({1'b0, coef_addr} < (AW+1)'(NC));
    assign w_last    = (r_k == AW'(NC - 1));
    assign w_kb      = AW'(TAPS - 1) - r_k;

    genvar gi;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_ch
            logic signed [DW-1:0] r_line [TAPS];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int t = 0; t < TAPS; t++) r_line[t] <= '0;
                end else if (w_accept && (xin_ch == CHW'(gi))) begin
                    r_line[0] <= xin;
                    for (int t = 1; t < TAPS; t++) r_line[t] <= r_line[t-1];
                end
            end

            // Mirror tap is only folded in when coefficients are symmetric
            assign w_xa[gi] = r_line[r_k];
            assign w_xb[gi] = (SYMM != 0) ? r_line[w_kb] : '0;
        end
    endgenerate

    assign w_pre  = (DW+1)'(w_xa[r_ch]) + (DW+1)'(w_xb[r_ch]);
    assign w_prod = r_coef[r_k] * w_pre;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        busy         = (r_state != S_IDLE);
        case (r_state)
            S_IDLE:  if (w_accept) w_state_next = S_MAC;
            S_MAC:   if (w_last)   w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_k     <= '0;
            r_ch    <= '0;
            r_acc   <= '0;
            yout    <= '0;
            yout_ch <= '0;
            rdy     <= 1'b0;
            err     <= 1'b0;
        end else begin
            rdy <= 1'b0;
            if (en && ((r_state != S_IDLE) || !w_ch_ok)) err <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_acc <= '0;
                        r_k   <= '0;
                        r_ch  <= xin_ch;
                    end
                end
                S_MAC: begin
                    r_acc <= r_acc + OW'(w_prod);
                    r_k   <= r_k + 1'b1;
                end
                S_DONE: begin
                    yout    <= r_acc;
                    yout_ch <= r_ch;
                    rdy     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < NC; n++) r_coef[n] <= '0;
        end else if (w_coef_wr) begin
            r_coef[coef_addr] <= coef_data;
        end
    end
endmodule
